game_flow_fsm: RTL and testbench

- Parametrised game-flow controller; successor of the 3-state pause/alive/dead sequencer.
- Adds a multi-life counter, a frame-timed countdown before each life, a timed dying phase and a terminal game-over state.
- Start is rising-edge detected internally.
- Sits between the input/keycode logic and the bird, pipe and score/VGA blocks, which read state_num, freeze and the count outputs.

---
 rtl/game_flow_fsm.sv | 187 ++++++++++++++++++
 tb/tb_game_flow_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_fsm.sv
// game_flow_fsm
//   Game-flow controller: IDLE -> COUNTDOWN -> ALIVE -> DYING -> (COUNTDOWN | GAME_OVER).
//   The game has a configurable number of lives. Each life begins with a countdown
//   timed in frames, and each kill is followed by a dying phase timed in frames.
//   The start key is edge-detected internally.
//
// Optional feature macro: GAME_PAUSE_EN
//   When defined, a start rising edge in ALIVE enters PAUSED, and a second rising
//   edge returns to ALIVE.
//
// Ports
//   Clk          in   system clock
//   Reset_n      in   asynchronous active-low reset
//   frame_tick   in   one-Clk pulse per video frame
//   start        in   start/continue key (level); only its rising edge is used
//   bird_killed  in   collision flag (level)
//   state_num    out  [2:0] IDLE=0 COUNTDOWN=1 ALIVE=2 DYING=3 GAME_OVER=4 PAUSED=5
//   killed_out   out  high in DYING and GAME_OVER
//   freeze       out  high in every state except ALIVE
//   game_over    out  high only in GAME_OVER
//   lives_left   out  [LIFE_W-1:0] remaining lives
//   frame_cnt    out  [CNT_W-1:0] frames remaining in COUNTDOWN/DYING, else 0
module game_flow_fsm #(
  parameter int LIVES            = 3,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int DEATH_FRAMES     = 120,
  parameter int LIFE_W           = $clog2(LIVES + 1),
  parameter int CNT_W            = $clog2(((COUNTDOWN_FRAMES > DEATH_FRAMES) ?
                                           COUNTDOWN_FRAMES : DEATH_FRAMES) + 1)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              bird_killed,
  output logic [2:0]        state_num,
  output logic              killed_out,
  output logic              freeze,
  output logic              game_over,
  output logic [LIFE_W-1:0] lives_left,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    ALIVE     = 3'd2,
    DYING     = 3'd3,
    GAME_OVER = 3'd4,
    PAUSED    = 3'd5
  } state_t;

  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);
  localparam logic [CNT_W-1:0]  CD_LOAD    = CNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0]  DF_LOAD    = CNT_W'(DEATH_FRAMES - 1);

  state_t            state, state_nx;
  logic [LIFE_W-1:0] lives, lives_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              start_q;
  logic              start_rise;

  // start_q keeps sampling start while reset is asserted. A key held down
  // through reset release is then already "seen", so it does not start a game
  // until the key is released and pressed again.
  always_ff @(posedge Clk) begin
    start_q <= start;
  end

  assign start_rise = start & ~start_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      lives <= LIVES_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      lives <= lives_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lives_nx = lives;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        lives_nx = LIVES_INIT;
        if (start_rise) begin
          state_nx = COUNTDOWN;
          cnt_nx   = CD_LOAD;
        end
      end
      COUNTDOWN: begin
        if (frame_tick) begin
          if (cnt == '0) state_nx = ALIVE;
          else           cnt_nx   = cnt - 1'b1;
        end
      end
      ALIVE: begin
        if (bird_killed) begin
          state_nx = DYING;
          lives_nx = (lives != '0) ? lives - 1'b1 : '0;
          cnt_nx   = DF_LOAD;
        end
`ifdef GAME_PAUSE_EN
        else if (start_rise) begin
          state_nx = PAUSED;
        end
`endif
      end
      DYING: begin
        if (frame_tick) begin
          if (cnt == '0) begin
            if (lives == '0) begin
              state_nx = GAME_OVER;
              cnt_nx   = '0;
            end else begin
              state_nx = COUNTDOWN;
              cnt_nx   = CD_LOAD;
            end
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
      end
      GAME_OVER: begin
        lives_nx = '0;
        if (start_rise) state_nx = IDLE;
      end
`ifdef GAME_PAUSE_EN
      PAUSED: begin
        if (start_rise) state_nx = ALIVE;
      end
`endif
      default: begin
        state_nx = IDLE;
        lives_nx = LIVES_INIT;
        cnt_nx   = '0;
      end
    endcase
  end

  assign lives_left = lives;

  always_comb begin
    state_num  = 3'd0;
    killed_out = 1'b0;
    freeze     = 1'b1;
    game_over  = 1'b0;
    frame_cnt  = '0;
    case (state)
      IDLE: begin
        state_num = 3'd0;
      end
      COUNTDOWN: begin
        state_num = 3'd1;
        frame_cnt = cnt;
      end
      ALIVE: begin
        state_num = 3'd2;
        freeze    = 1'b0;
      end
      DYING: begin
        state_num  = 3'd3;
        killed_out = 1'b1;
        frame_cnt  = cnt;
      end
      GAME_OVER: begin
        state_num  = 3'd4;
        killed_out = 1'b1;
        game_over  = 1'b1;
      end
`ifdef GAME_PAUSE_EN
      PAUSED: begin
        state_num = 3'd5;
      end
`endif
      default: begin
        state_num = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_game_flow_fsm.sv
// tb_game_flow_fsm
//   Self-checking bench for game_flow_fsm (LIVES=2, COUNTDOWN_FRAMES=3, DEATH_FRAMES=2).
//   The bench runs directed scenarios followed by a randomized run. Both are checked
//   against a reference model that counts elapsed frames per phase. Paused-game
//   scenarios are included when GAME_PAUSE_EN is defined.
module tb_game_flow_fsm;

  localparam int LIVES  = 2;
  localparam int CDF    = 3;
  localparam int DF     = 2;
  localparam int LIFE_W = $clog2(LIVES + 1);
  localparam int CNT_W  = $clog2(((CDF > DF) ? CDF : DF) + 1);

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  localparam int P_IDLE = 0, P_CD = 1, P_ALIVE = 2, P_DYING = 3, P_OVER = 4, P_PAUSED = 5;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              frame_tick, start, bird_killed;
  logic [2:0]        state_num;
  logic              killed_out, freeze, game_over;
  logic [LIFE_W-1:0] lives_left;
  logic [CNT_W-1:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the current phase, lives, the frames already spent in
  // the current timed phase, and the last sampled level of the start key.
  int m_phase, m_lives, m_ticks;
  bit m_prev_start;

  game_flow_fsm #(
    .LIVES(LIVES),
    .COUNTDOWN_FRAMES(CDF),
    .DEATH_FRAMES(DF)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_tick(frame_tick),
    .start(start),
    .bird_killed(bird_killed),
    .state_num(state_num),
    .killed_out(killed_out),
    .freeze(freeze),
    .game_over(game_over),
    .lives_left(lives_left),
    .frame_cnt(frame_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_lives = LIVES;
    m_ticks = 0;
  endtask

  task automatic model_step();
    bit rise;
    rise = start && !m_prev_start;
    case (m_phase)
      P_IDLE: begin
        m_lives = LIVES;
        if (rise) begin m_phase = P_CD; m_ticks = 0; end
      end
      P_CD: if (frame_tick) begin
        if (m_ticks == CDF - 1) m_phase = P_ALIVE;
        else m_ticks++;
      end
      P_ALIVE: begin
        if (bird_killed) begin
          m_phase = P_DYING;
          m_ticks = 0;
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        end else if (PAUSE && rise) begin
          m_phase = P_PAUSED;
        end
      end
      P_DYING: if (frame_tick) begin
        if (m_ticks == DF - 1) begin
          m_phase = (m_lives == 0) ? P_OVER : P_CD;
          m_ticks = 0;
        end else begin
          m_ticks++;
        end
      end
      P_OVER: begin
        m_lives = 0;
        if (rise) m_phase = P_IDLE;
      end
      P_PAUSED: if (rise) m_phase = P_ALIVE;
      default: m_phase = P_IDLE;
    endcase
    m_prev_start = start;
  endtask

  task automatic check_model(input string tag);
    int exp_cnt;
    exp_cnt = (m_phase == P_CD) ? (CDF - 1 - m_ticks) :
              (m_phase == P_DYING) ? (DF - 1 - m_ticks) : 0;
    chk({tag, ".state_num"}, state_num, m_phase);
    chk({tag, ".killed_out"}, killed_out, (m_phase == P_DYING || m_phase == P_OVER) ? 1 : 0);
    chk({tag, ".freeze"}, freeze, (m_phase != P_ALIVE) ? 1 : 0);
    chk({tag, ".game_over"}, game_over, (m_phase == P_OVER) ? 1 : 0);
    chk({tag, ".lives_left"}, lives_left, m_lives);
    chk({tag, ".frame_cnt"}, frame_cnt, exp_cnt);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".state_num"}, state_num, 0);
    chk({tag, ".killed_out"}, killed_out, 0);
    chk({tag, ".freeze"}, freeze, 1);
    chk({tag, ".game_over"}, game_over, 0);
    chk({tag, ".lives_left"}, lives_left, LIVES);
    chk({tag, ".frame_cnt"}, frame_cnt, 0);
  endtask

  // Call at a negedge. Inputs are applied here, the edge is taken, and outputs
  // are checked at the following negedge.
  task automatic step(input bit s, input bit t, input bit k, input string tag);
    start = s; frame_tick = t; bird_killed = k;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check_model(tag);
  endtask

  task automatic hold_reset(input int n);
    Reset_n = 1'b0;
    model_reset();
    repeat (n) begin
      @(posedge Clk);
      m_prev_start = start;
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
  endtask

  initial begin
    Reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0; bird_killed = 1'b0;
    m_prev_start = 1'b0;
    hold_reset(2);
    check_reset_values("reset");

    // Start rise -> COUNTDOWN one edge later, then three ticks -> ALIVE.
    step(1, 0, 0, "start");
    chk("start_cd_state", state_num, 1);
    chk("start_cd_cnt", frame_cnt, 2);
    step(0, 0, 0, "cd_idle");
    step(0, 1, 0, "cd_t1");
    step(0, 1, 0, "cd_t2");
    step(0, 1, 0, "cd_t3");
    chk("alive_state", state_num, 2);
    chk("alive_freeze", freeze, 0);
    chk("alive_cnt", frame_cnt, 0);

    // A held kill level costs one life only.
    step(0, 1, 1, "kill1");
    for (int i = 0; i < 49; i++) step(0, 0, 1, "kill1_hold");
    chk("kill1_lives", lives_left, 1);
    chk("kill1_killed", killed_out, 1);
    chk("kill1_state", state_num, 3);
    step(0, 1, 0, "dy_t1");
    step(0, 1, 0, "dy_t2");
    chk("dy_back_state", state_num, 1);
    chk("dy_back_cnt", frame_cnt, 2);

    // Last life -> GAME_OVER -> IDLE. Lives reload one cycle later.
    for (int i = 0; i < 3; i++) step(0, 1, 0, "cd2");
    step(0, 0, 1, "kill2");
    chk("kill2_lives", lives_left, 0);
    chk("kill2_state", state_num, 3);
    step(0, 1, 0, "dy2_t1");
    step(0, 1, 0, "dy2_t2");
    chk("over_state", state_num, 4);
    chk("over_flag", game_over, 1);
    step(1, 0, 0, "restart");
    chk("restart_state", state_num, 0);
    step(0, 0, 0, "reload");
    chk("reload_lives", lives_left, 2);

    // start held across reset release produces no rise.
    start = 1'b1;
    hold_reset(2);
    for (int i = 0; i < 10; i++) step(1, 0, 0, "held");
    chk("held_state", state_num, 0);
    step(0, 0, 0, "release");
    step(1, 0, 0, "repress");
    chk("repress_state", state_num, 1);

    // Asynchronous reset while in DYING takes effect between edges.
    for (int i = 0; i < 3; i++) step(0, 1, 0, "cd3");
    step(0, 0, 1, "kill3");
    chk("kill3_state", state_num, 3);
    #2 Reset_n = 1'b0;
    #1 check_reset_values("async_rst");
    hold_reset(1);
    check_reset_values("async_rel");

`ifdef GAME_PAUSE_EN
    step(1, 0, 0, "p_start");
    step(0, 0, 0, "p_s0");
    for (int i = 0; i < 3; i++) step(0, 1, 0, "p_cd");
    step(1, 0, 0, "p_pause");
    chk("pause_state", state_num, 5);
    step(0, 0, 0, "p_rel");
    for (int i = 0; i < 5; i++) step(0, 1, 1, "p_hold");
    chk("pause_hold", state_num, 5);
    step(1, 0, 0, "p_resume");
    chk("resume_state", state_num, 2);
    step(0, 0, 0, "p_rel2");
    step(1, 0, 1, "p_prio");
    chk("prio_state", state_num, 3);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 11) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
